// File: rtl/reorder_buffer_if.sv
// Rename/CDB/commit signal bundle for reorder_buffer.
// master = rename stage + CDB driver, slave = the reorder buffer itself.
interface reorder_buffer_if #(
  parameter int ROB_DEPTH = 8
);
  localparam int TW = $clog2(ROB_DEPTH);

  logic          dispatch_valid;
  logic [4:0]    dispatch_arch_dest;
  logic [4:0]    dispatch_phys_dest;
  logic [4:0]    dispatch_phys_old;
  logic          dispatch_ready;
  logic [TW-1:0] dispatch_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic          commit_valid;
  logic          commit_flag;
  logic [4:0]    commit_phys_reg;
  logic [4:0]    commit_arch_dest;
  logic [4:0]    commit_phys_dest;
  logic          empty;

  modport master (
    output dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_old,
    output cdb_valid, cdb_tag,
    input  dispatch_ready, dispatch_tag,
    input  commit_valid, commit_flag, commit_phys_reg, commit_arch_dest, commit_phys_dest,
    input  empty
  );

  modport slave (
    input  dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_old,
    input  cdb_valid, cdb_tag,
    output dispatch_ready, dispatch_tag,
    output commit_valid, commit_flag, commit_phys_reg, commit_arch_dest, commit_phys_dest,
    output empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer for renamed instructions, one dispatch and one retire per cycle.
// Optional macro ROB_CDB_BYPASS_EN: a completion on the head entry retires it at the same edge.
module reorder_buffer #(
  parameter int ROB_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  rob
);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam logic [TW:0]   FULL    = (TW+1)'(ROB_DEPTH);
  localparam logic [TW:0]   CNT_ONE = (TW+1)'(1);
  localparam logic [TW-1:0] PTR_ONE = TW'(1);

  logic [TW-1:0]        head_q, tail_q;
  logic [TW:0]          count_q, count_d;
  logic [ROB_DEPTH-1:0] busy_q, done_q;
  logic [4:0]           arch_q [ROB_DEPTH];
  logic [4:0]           pdst_q [ROB_DEPTH];
  logic [4:0]           pold_q [ROB_DEPTH];

  logic                 cvalid_q, cflag_q;
  logic [4:0]           cphys_q, carch_q, cpdst_q;

  logic                 disp_fire, cdb_hit, retire;

  always_comb begin
    disp_fire = rob.dispatch_valid && (count_q != FULL);
    cdb_hit   = rob.cdb_valid && busy_q[rob.cdb_tag] && !done_q[rob.cdb_tag];
`ifdef ROB_CDB_BYPASS_EN
    retire    = busy_q[head_q] &&
                (done_q[head_q] || (cdb_hit && (rob.cdb_tag == head_q)));
`else
    retire    = busy_q[head_q] && done_q[head_q];
`endif
    count_d = count_q;
    if (disp_fire && !retire)      count_d = count_q + CNT_ONE;
    else if (!disp_fire && retire) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      done_q   <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        arch_q[i] <= '0;
        pdst_q[i] <= '0;
        pold_q[i] <= '0;
      end
      cvalid_q <= 1'b0;
      cflag_q  <= 1'b0;
      cphys_q  <= '0;
      carch_q  <= '0;
      cpdst_q  <= '0;
    end else begin
      count_q <= count_d;
      if (cdb_hit) done_q[rob.cdb_tag] <= 1'b1;
      // Retire clear is ordered after the cdb set so a bypassed head entry ends up idle.
      if (retire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + PTR_ONE;
      end
      if (disp_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        arch_q[tail_q] <= rob.dispatch_arch_dest;
        pdst_q[tail_q] <= rob.dispatch_phys_dest;
        pold_q[tail_q] <= rob.dispatch_phys_old;
        tail_q         <= tail_q + PTR_ONE;
      end
      cvalid_q <= retire;
      cflag_q  <= retire && (arch_q[head_q] != 5'd0);
      cphys_q  <= retire ? pold_q[head_q] : 5'd0;
      carch_q  <= retire ? arch_q[head_q] : 5'd0;
      cpdst_q  <= retire ? pdst_q[head_q] : 5'd0;
    end
  end

  assign rob.dispatch_ready   = (count_q != FULL);
  assign rob.dispatch_tag     = tail_q;
  assign rob.empty            = (count_q == '0);
  assign rob.commit_valid     = cvalid_q;
  assign rob.commit_flag      = cflag_q;
  assign rob.commit_phys_reg  = cphys_q;
  assign rob.commit_arch_dest = carch_q;
  assign rob.commit_phys_dest = cpdst_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (ROB_DEPTH = 8).
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_DEPTH(8)) rob ();
  reorder_buffer #(.ROB_DEPTH(8)) dut (.clk(clk), .reset(reset), .rob(rob));

`ifdef ROB_CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  task automatic idle_inputs();
    rob.dispatch_valid     = 1'b0;
    rob.dispatch_arch_dest = 5'd0;
    rob.dispatch_phys_dest = 5'd0;
    rob.dispatch_phys_old  = 5'd0;
    rob.cdb_valid          = 1'b0;
    rob.cdb_tag            = 3'd0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    cycle();
    reset = 1'b0;
  endtask

  task automatic dispatch(input int a, input int p, input int o);
    rob.dispatch_valid     = 1'b1;
    rob.dispatch_arch_dest = 5'(a);
    rob.dispatch_phys_dest = 5'(p);
    rob.dispatch_phys_old  = 5'(o);
    cycle();
    rob.dispatch_valid     = 1'b0;
  endtask

  task automatic complete(input int t);
    rob.cdb_valid = 1'b1;
    rob.cdb_tag   = 3'(t);
    cycle();
    rob.cdb_valid = 1'b0;
  endtask

  // Advances at most 4 cycles until a commit is visible.
  task automatic wait_commit();
    int w = 0;
    while (rob.commit_valid !== 1'b1 && w < 4) begin
      cycle();
      w++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    total++; if (rob.commit_valid !== 1'b0) begin bad++; $display("FAIL reset_cvalid got=%0d exp=0", rob.commit_valid); end
    total++; if (rob.commit_flag !== 1'b0) begin bad++; $display("FAIL reset_cflag got=%0d exp=0", rob.commit_flag); end
    total++; if (rob.commit_phys_reg !== 5'd0) begin bad++; $display("FAIL reset_cphys got=%0d exp=0", rob.commit_phys_reg); end
    total++; if (rob.commit_arch_dest !== 5'd0) begin bad++; $display("FAIL reset_carch got=%0d exp=0", rob.commit_arch_dest); end
    total++; if (rob.commit_phys_dest !== 5'd0) begin bad++; $display("FAIL reset_cpdst got=%0d exp=0", rob.commit_phys_dest); end
    total++; if (rob.dispatch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0d exp=1", rob.dispatch_ready); end
    total++; if (rob.dispatch_tag !== 3'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", rob.dispatch_tag); end
    total++; if (rob.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0d exp=1", rob.empty); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    dispatch(3, 7, 3);
    total++; if (rob.dispatch_tag !== 3'd1) begin bad++; $display("FAIL single_tag got=%0d exp=1", rob.dispatch_tag); end
    total++; if (rob.empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%0d exp=0", rob.empty); end
    complete(0);
`ifndef ROB_CDB_BYPASS_EN
    total++; if (rob.commit_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0d exp=0", rob.commit_valid); end
    cycle();
`endif
    total++; if (rob.commit_valid !== 1'b1) begin bad++; $display("FAIL single_cvalid got=%0d exp=1", rob.commit_valid); end
    total++; if (rob.commit_flag !== 1'b1) begin bad++; $display("FAIL single_cflag got=%0d exp=1", rob.commit_flag); end
    total++; if (rob.commit_phys_reg !== 5'd3) begin bad++; $display("FAIL single_cphys got=%0d exp=3", rob.commit_phys_reg); end
    total++; if (rob.commit_arch_dest !== 5'd3) begin bad++; $display("FAIL single_carch got=%0d exp=3", rob.commit_arch_dest); end
    total++; if (rob.commit_phys_dest !== 5'd7) begin bad++; $display("FAIL single_cpdst got=%0d exp=7", rob.commit_phys_dest); end
    cycle();
    total++; if (rob.commit_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0d exp=0", rob.commit_valid); end
    total++; if (rob.commit_phys_reg !== 5'd0) begin bad++; $display("FAIL single_cphys_idle got=%0d exp=0", rob.commit_phys_reg); end
    total++; if (rob.empty !== 1'b1) begin bad++; $display("FAIL single_empty_end got=%0d exp=1", rob.empty); end
  endtask

  task automatic test_out_of_order();
    int order [3] = '{2, 0, 1};
    int earch [3] = '{1, 2, 4};
    int eold  [3] = '{20, 21, 22};
    int n = 0;
    int first = -1;
    int last = -1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      total++; if (rob.dispatch_tag !== 3'(i)) begin bad++; $display("FAIL ooo_tag%0d got=%0d exp=%0d", i, rob.dispatch_tag, i); end
      dispatch(earch[i], 10 + i, eold[i]);
    end
    for (int c = 0; c < 8; c++) begin
      rob.cdb_valid = (c < 3);
      rob.cdb_tag   = (c < 3) ? 3'(order[c]) : 3'd0;
      cycle();
      if (rob.commit_valid === 1'b1) begin
        if (n < 3) begin
          total++; if (rob.commit_arch_dest !== 5'(earch[n])) begin bad++; $display("FAIL ooo_arch%0d got=%0d exp=%0d", n, rob.commit_arch_dest, earch[n]); end
          total++; if (rob.commit_phys_reg !== 5'(eold[n])) begin bad++; $display("FAIL ooo_phys%0d got=%0d exp=%0d", n, rob.commit_phys_reg, eold[n]); end
        end
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    rob.cdb_valid = 1'b0;
    total++; if (n != 3) begin bad++; $display("FAIL ooo_count got=%0d exp=3", n); end
    total++; if (first != LAT) begin bad++; $display("FAIL ooo_first got=%0d exp=%0d", first, LAT); end
    total++; if (last - first != 2) begin bad++; $display("FAIL ooo_span got=%0d exp=2", last - first); end
    total++; if (rob.empty !== 1'b1) begin bad++; $display("FAIL ooo_empty got=%0d exp=1", rob.empty); end
  endtask

  task automatic test_full();
    int got [8];
    int n = 0;
    do_reset();
    for (int i = 0; i < 8; i++) dispatch(i + 1, i + 8, i + 16);
    total++; if (rob.dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0d exp=0", rob.dispatch_ready); end
    total++; if (rob.dispatch_tag !== 3'd0) begin bad++; $display("FAIL full_tag got=%0d exp=0", rob.dispatch_tag); end
    dispatch(31, 30, 29);
    total++; if (rob.dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_ninth_ready got=%0d exp=0", rob.dispatch_ready); end
    total++; if (rob.dispatch_tag !== 3'd0) begin bad++; $display("FAIL full_ninth_tag got=%0d exp=0", rob.dispatch_tag); end
    complete(0);
    wait_commit();
    total++; if (rob.commit_valid !== 1'b1) begin bad++; $display("FAIL full_commit_timeout got=%0d exp=1", rob.commit_valid); end
    total++; if (rob.commit_arch_dest !== 5'd1) begin bad++; $display("FAIL full_carch got=%0d exp=1", rob.commit_arch_dest); end
    total++; if (rob.commit_phys_reg !== 5'd16) begin bad++; $display("FAIL full_cphys got=%0d exp=16", rob.commit_phys_reg); end
    total++; if (rob.dispatch_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%0d exp=1", rob.dispatch_ready); end
    total++; if (rob.dispatch_tag !== 3'd0) begin bad++; $display("FAIL full_tag_after got=%0d exp=0", rob.dispatch_tag); end
    dispatch(9, 17, 25);
    for (int c = 0; c < 20; c++) begin
      rob.cdb_valid = (c < 8);
      rob.cdb_tag   = 3'((c + 1) % 8);
      cycle();
      if (rob.commit_valid === 1'b1) begin
        if (n < 8) got[n] = int'(rob.commit_arch_dest);
        n++;
      end
    end
    rob.cdb_valid = 1'b0;
    total++; if (n != 8) begin bad++; $display("FAIL full_drain_count got=%0d exp=8", n); end
    for (int k = 0; k < 8 && k < n; k++) begin
      total++; if (got[k] != k + 2) begin bad++; $display("FAIL full_order%0d got=%0d exp=%0d", k, got[k], k + 2); end
    end
    total++; if (rob.empty !== 1'b1) begin bad++; $display("FAIL full_empty got=%0d exp=1", rob.empty); end
  endtask

  task automatic test_x0();
    do_reset();
    dispatch(0, 0, 0);
    complete(0);
    wait_commit();
    total++; if (rob.commit_valid !== 1'b1) begin bad++; $display("FAIL x0_cvalid got=%0d exp=1", rob.commit_valid); end
    total++; if (rob.commit_flag !== 1'b0) begin bad++; $display("FAIL x0_cflag got=%0d exp=0", rob.commit_flag); end
    total++; if (rob.commit_phys_reg !== 5'd0) begin bad++; $display("FAIL x0_cphys got=%0d exp=0", rob.commit_phys_reg); end
    cycle();
    dispatch(0, 5, 6);
    complete(1);
    wait_commit();
    total++; if (rob.commit_valid !== 1'b1) begin bad++; $display("FAIL x0b_cvalid got=%0d exp=1", rob.commit_valid); end
    total++; if (rob.commit_flag !== 1'b0) begin bad++; $display("FAIL x0b_cflag got=%0d exp=0", rob.commit_flag); end
    total++; if (rob.commit_phys_reg !== 5'd6) begin bad++; $display("FAIL x0b_cphys got=%0d exp=6", rob.commit_phys_reg); end
    total++; if (rob.commit_phys_dest !== 5'd5) begin bad++; $display("FAIL x0b_cpdst got=%0d exp=5", rob.commit_phys_dest); end
    cycle();
  endtask

  task automatic test_wrap();
    int t = 2;
    int n = 0;
    for (int r = 0; r < 20; r++) begin
      total++; if (rob.dispatch_tag !== 3'(t)) begin bad++; $display("FAIL wrap_tag r%0d got=%0d exp=%0d", r, rob.dispatch_tag, t); end
      dispatch((r % 31) + 1, r, r + 1);
      complete(t);
      wait_commit();
      if (rob.commit_valid === 1'b1) n++;
      total++; if (rob.commit_arch_dest !== 5'((r % 31) + 1)) begin bad++; $display("FAIL wrap_arch r%0d got=%0d exp=%0d", r, rob.commit_arch_dest, (r % 31) + 1); end
      total++; if (rob.commit_phys_reg !== 5'(r + 1)) begin bad++; $display("FAIL wrap_phys r%0d got=%0d exp=%0d", r, rob.commit_phys_reg, r + 1); end
      complete(t);
      total++; if (rob.commit_valid !== 1'b0) begin bad++; $display("FAIL wrap_dup1 r%0d got=%0d exp=0", r, rob.commit_valid); end
      cycle();
      total++; if (rob.commit_valid !== 1'b0) begin bad++; $display("FAIL wrap_dup2 r%0d got=%0d exp=0", r, rob.commit_valid); end
      t = (t + 1) % 8;
    end
    total++; if (n != 20) begin bad++; $display("FAIL wrap_count got=%0d exp=20", n); end
    total++; if (rob.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0d exp=1", rob.empty); end
    total++; if (rob.dispatch_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%0d exp=1", rob.dispatch_ready); end
  endtask

  task automatic test_reset_mid();
    int flags = 0;
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5 + i, 10 + i, 20 + i);
    complete(1);
    if (rob.commit_flag === 1'b1) flags++;
    complete(2);
    if (rob.commit_flag === 1'b1) flags++;
    reset = 1'b1;
    rob.dispatch_valid     = 1'b1;
    rob.dispatch_arch_dest = 5'd9;
    rob.cdb_valid          = 1'b1;
    rob.cdb_tag            = 3'd0;
    cycle();
    reset = 1'b0;
    idle_inputs();
    total++; if (rob.commit_valid !== 1'b0) begin bad++; $display("FAIL rmid_cvalid got=%0d exp=0", rob.commit_valid); end
    total++; if (rob.empty !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%0d exp=1", rob.empty); end
    total++; if (rob.dispatch_tag !== 3'd0) begin bad++; $display("FAIL rmid_tag got=%0d exp=0", rob.dispatch_tag); end
    total++; if (rob.dispatch_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0d exp=1", rob.dispatch_ready); end
    for (int c = 0; c < 4; c++) begin
      if (rob.commit_flag === 1'b1) flags++;
      cycle();
    end
    total++; if (flags != 0) begin bad++; $display("FAIL rmid_flags got=%0d exp=0", flags); end
    total++; if (rob.empty !== 1'b1) begin bad++; $display("FAIL rmid_empty_later got=%0d exp=1", rob.empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_x0();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
